// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed, byte-lane data memory.
// Accepts one request at a time, performs a single-cycle access and returns a one-cycle response.
module mem_access_unit #(
   parameter int MEM_AW = 21
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [29:0] o_mem_address,
   output logic [3:0]  o_mem_sel_width,
   output logic        o_mem_w_en,
   output logic [31:0] o_mem_din,
   input  logic [31:0] i_mem_dout,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge where i_req_valid && o_req_ready;
   // the requester holds its request stable until then. o_rsp_valid is a single-cycle pulse.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        accept, req_err;
   logic [3:0]  sel_new, sel_q;
   logic [31:0] din_new, load_ext;
   logic        we_q, uns_q;
   logic [1:0]  size_q, lane_q;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign dbg_state = state;
   assign accept    = (state == IDLE) && i_req_valid;

   always_comb begin
      req_err = 1'b0;
      if (i_req_size == 2'd3)                               req_err = 1'b1;
      if (i_req_size == 2'd1 && i_req_addr[0])              req_err = 1'b1;
      if (i_req_size == 2'd2 && i_req_addr[1:0] != 2'd0)    req_err = 1'b1;
      if ((i_req_addr >> (MEM_AW + 2)) != 32'd0)            req_err = 1'b1;
   end

   // Lane enables and replicated write data for the incoming request.
   always_comb begin
      sel_new = 4'b0000;
      din_new = i_req_wdata;
      case (i_req_size)
         2'd0: begin
            sel_new = 4'b0001 << i_req_addr[1:0];
            din_new = {4{i_req_wdata[7:0]}};
         end
         2'd1: begin
            sel_new = i_req_addr[1] ? 4'b1100 : 4'b0011;
            din_new = {2{i_req_wdata[15:0]}};
         end
         default: sel_new = 4'b1111;
      endcase
   end

   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = i_mem_dout[7:0];
         2'd1:    ld_byte = i_mem_dout[15:8];
         2'd2:    ld_byte = i_mem_dout[23:16];
         default: ld_byte = i_mem_dout[31:24];
      endcase
      ld_half = lane_q[1] ? i_mem_dout[31:16] : i_mem_dout[15:0];
      case (size_q)
         2'd0:    load_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'd1:    load_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_ext = i_mem_dout;
      endcase
   end

   // Reset gates the memory strobes and response so an interrupted access has no effect.
   always_comb begin
      state_nxt       = state;
      o_req_ready     = (state == IDLE);
      o_rsp_valid     = 1'b0;
      o_mem_sel_width = 4'b0000;
      o_mem_w_en      = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = req_err ? RESP : ACCESS;
         ACCESS: begin
            o_mem_sel_width = i_rst ? 4'b0000 : sel_q;
            o_mem_w_en      = we_q && !i_rst;
            state_nxt       = RESP;
         end
         RESP: begin
            o_rsp_valid = !i_rst;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         uns_q         <= 1'b0;
         size_q        <= 2'd0;
         lane_q        <= 2'd0;
         sel_q         <= 4'b0000;
         o_mem_address <= 30'd0;
         o_mem_din     <= 32'd0;
         o_rsp_rdata   <= 32'd0;
         o_rsp_err     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            we_q   <= i_req_we;
            uns_q  <= i_req_unsigned;
            size_q <= i_req_size;
            lane_q <= i_req_addr[1:0];
            if (req_err) begin
               o_rsp_err <= 1'b1;
            end else begin
               sel_q         <= sel_new;
               o_mem_address <= i_req_addr[31:2];
               o_mem_din     <= din_new;
            end
         end
         if (state == ACCESS && !we_q) o_rsp_rdata <= load_ext;
         if (state == RESP) begin
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-lane memory model on the memory port.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [29:0] mem_address;
   logic [3:0]  mem_sel;
   logic        mem_w_en;
   logic [31:0] mem_din, mem_dout;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Observations from the last do_req call.
   int          r_lat, r_acc;
   logic [31:0] r_rdata, r_din;
   logic        r_err, r_wen;
   logic [29:0] r_addr;
   logic [3:0]  r_sel;

   logic [31:0] exp_q[$];

   mem_access_unit #(.MEM_AW(21)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_mem_address(mem_address), .o_mem_sel_width(mem_sel), .o_mem_w_en(mem_w_en),
      .o_mem_din(mem_din), .i_mem_dout(mem_dout), .dbg_state(dbg_state)
   );

   // Clock and memory model
   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   logic        mem_clear;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      end else if (mem_w_en) begin
         for (int k = 0; k < 4; k++)
            if (mem_sel[k]) mem[mem_address[9:0]][8*k +: 8] <= mem_din[8*k +: 8];
      end
   end

   always_comb begin
      mem_dout = 32'd0;
      for (int k = 0; k < 4; k++)
         if (mem_sel[k]) mem_dout[8*k +: 8] = mem[mem_address[9:0]][8*k +: 8];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Driver: issue one request, wait for its response, record what the memory port showed.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      bit got;
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      check("ready_before_req", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      r_lat = 0; r_acc = 0; got = 0;
      r_rdata = 32'hx; r_err = 1'bx; r_din = 32'd0; r_wen = 1'b0; r_addr = 30'd0; r_sel = 4'd0;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge clk);
         if (mem_sel != 4'd0 || mem_w_en) begin
            r_acc++; r_addr = mem_address; r_sel = mem_sel; r_din = mem_din; r_wen = mem_w_en;
         end
         if (rsp_valid) begin
            got = 1; r_lat = c; r_rdata = rsp_rdata; r_err = rsp_err;
         end
      end
      @(negedge clk);
      check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
      check("rdata_cleared", rsp_rdata, 32'd0);
   endtask

   task automatic expect_ok(input string tag, input logic [31:0] rdata);
      check({tag, "_lat"}, r_lat, 2);
      check({tag, "_err"}, {31'd0, r_err}, 32'd0);
      check({tag, "_rdata"}, r_rdata, rdata);
      check({tag, "_acc_cycles"}, r_acc, 1);
   endtask

   task automatic expect_err(input string tag);
      check({tag, "_lat"}, r_lat, 1);
      check({tag, "_err"}, {31'd0, r_err}, 32'd1);
      check({tag, "_rdata"}, r_rdata, 32'd0);
      check({tag, "_no_access"}, r_acc, 0);
   endtask

   initial begin
      int acc_cyc[3];
      int idx, n_rsp;
      bit take;
      logic [31:0] ld_addr[3];
      logic [1:0]  ld_size[3];
      logic        ld_uns[3];

      rst = 1'b1; mem_clear = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; mem_clear = 1'b0;

      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_mem_addr", {2'd0, mem_address}, 32'd0);
      check("rst_sel_wen", {27'd0, mem_sel, mem_w_en}, 32'd0);
      check("rst_din", mem_din, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);

      // Word store / load
      do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      expect_ok("sw", 32'd0);
      check("sw_addr", {2'd0, r_addr}, 32'h40);
      check("sw_sel", {28'd0, r_sel}, 32'hF);
      check("sw_wen", {31'd0, r_wen}, 32'd1);
      check("sw_din", r_din, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
      expect_ok("lw", 32'hDEADBEEF);
      check("lw_wen", {31'd0, r_wen}, 32'd0);
      check("lw_sel", {28'd0, r_sel}, 32'hF);

      // Byte store and signed/unsigned byte loads
      do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h00000080);
      expect_ok("sb", 32'd0);
      check("sb_sel", {28'd0, r_sel}, 32'h8);
      check("sb_din", r_din, 32'h80808080);
      do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
      expect_ok("lb", 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
      expect_ok("lbu", 32'h00000080);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
      expect_ok("lw_after_sb", 32'h80ADBEEF);

      // Halfword store and loads
      do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h00008001);
      expect_ok("sh", 32'd0);
      check("sh_sel", {28'd0, r_sel}, 32'hC);
      check("sh_din", r_din, 32'h80018001);
      do_req(1'b0, 2'd1, 1'b0, 32'h202, 32'd0);
      expect_ok("lh", 32'hFFFF8001);
      do_req(1'b0, 2'd1, 1'b1, 32'h202, 32'd0);
      expect_ok("lhu", 32'h00008001);
      do_req(1'b0, 2'd0, 1'b1, 32'h201, 32'd0);
      expect_ok("lbu_lane1", 32'h00000000);

      // Error cases
      do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
      expect_err("err_lw_mis");
      do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'd0);
      expect_err("err_lh_mis");
      do_req(1'b1, 2'd3, 1'b0, 32'h104, 32'h12345678);
      expect_err("err_size3");
      do_req(1'b1, 2'd2, 1'b0, 32'h0800_0000, 32'h12345678);
      expect_err("err_range");
      do_req(1'b0, 2'd2, 1'b0, 32'h0080_0000, 32'd0);
      expect_err("err_range_edge");

      // Back-to-back loads with valid held high
      ld_addr[0] = 32'h100; ld_size[0] = 2'd2; ld_uns[0] = 1'b0; exp_q.push_back(32'h80ADBEEF);
      ld_addr[1] = 32'h103; ld_size[1] = 2'd0; ld_uns[1] = 1'b1; exp_q.push_back(32'h00000080);
      ld_addr[2] = 32'h202; ld_size[2] = 2'd1; ld_uns[2] = 1'b0; exp_q.push_back(32'hFFFF8001);
      @(negedge clk);
      idx = 0; n_rsp = 0;
      req_we = 1'b0; req_wdata = 32'd0;
      req_addr = ld_addr[0]; req_size = ld_size[0]; req_unsigned = ld_uns[0];
      req_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid) begin
            n_rsp++;
            if (exp_q.size() > 0) check("b2b_rdata", rsp_rdata, exp_q.pop_front());
            else check("b2b_extra_rsp", {31'd0, rsp_valid}, 32'd0);
         end
         take = req_ready && req_valid;
         if (take) acc_cyc[idx] = c;
         @(posedge clk);
         #1;
         if (take) begin
            idx++;
            if (idx < 3) begin
               req_addr = ld_addr[idx]; req_size = ld_size[idx]; req_unsigned = ld_uns[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      check("b2b_accepts", idx, 3);
      check("b2b_rsp_count", n_rsp, 3);
      check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
      check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);

      // Reset during the ACCESS cycle of a store
      do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h11223344);
      expect_ok("sw300", 32'd0);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h300; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst_access_wen", {31'd0, mem_w_en}, 32'd0);
      check("rst_access_sel", {28'd0, mem_sel}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
      check("post_rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
      check("post_rst_addr", {2'd0, mem_address}, 32'd0);
      check("post_rst_din", mem_din, 32'd0);
      check("post_rst_state", {30'd0, dbg_state}, 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
      expect_ok("lw300", 32'h11223344);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
